// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the rst_seq reset sequencer.
// Optional debounce is selected with the RST_SEQ_DEBOUNCE_EN macro.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam int unsigned SEQ_COUNT_W = 32'd8;
  localparam logic [SEQ_COUNT_W-1:0] SEQ_COUNT_MAX = 8'hFF;

  // Bits needed to hold 0..max_count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = $clog2(max_count + 32'd1);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/rst_seq_debounce.sv
// Soft-request conditioning: 2-flop synchroniser, optional debounce
// (RST_SEQ_DEBOUNCE_EN) and rising-edge detector producing a one-cycle pulse.
module rst_seq_debounce
  import rst_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic soft_req_i,
  output logic req_pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic qual_q;
  logic pulse_q;
  logic qual_s;

`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int unsigned DEB_W = cnt_width(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 32'd1);

  logic [DEB_W-1:0] deb_cnt_q;

  // Consecutive-high counter; saturates so a held request stays qualified.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_cnt_q <= '0;
    end else if (!sync2_q) begin
      deb_cnt_q <= '0;
    end else if (deb_cnt_q != DEB_LAST) begin
      deb_cnt_q <= deb_cnt_q + 1'b1;
    end else begin
      deb_cnt_q <= deb_cnt_q;
    end
  end

  assign qual_s = sync2_q && (deb_cnt_q == DEB_LAST);
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign qual_s = sync2_q;
`endif

  // Synchroniser and registered rising-edge detect of the qualified level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      qual_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= soft_req_i;
      sync2_q <= sync1_q;
      qual_q  <= qual_s;
      pulse_q <= qual_s & ~qual_q;
    end
  end

  assign req_pulse_o = pulse_q;

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: holds all domains, releases SYS_RST, then staggers the
// per-unit resets. Soft-request debounce is enabled by RST_SEQ_DEBOUNCE_EN.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_UNITS       = 32'd4,
  parameter int unsigned HOLD_CYCLES     = 32'd4,
  parameter int unsigned STAGGER_CYCLES  = 32'd16,
  parameter int unsigned DEBOUNCE_CYCLES = 32'd1024
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SOFT_REQ,
  output logic                   SYS_RST,
  output logic [NUM_UNITS-1:0]   UNIT_RST,
  output logic                   READY,
  output logic [SEQ_COUNT_W-1:0] SEQ_COUNT
);

  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES - 32'd1);
  localparam int unsigned GAP_W  = cnt_width(STAGGER_CYCLES - 32'd1);
  localparam int unsigned IDX_W  = cnt_width(NUM_UNITS - 32'd1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGGER_CYCLES - 32'd1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_UNITS - 32'd1);

  state_e                 state_q;
  logic [HOLD_W-1:0]      hold_cnt_q;
  logic [GAP_W-1:0]       gap_cnt_q;
  logic [IDX_W-1:0]       unit_idx_q;
  logic                   sys_rst_q;
  logic [NUM_UNITS-1:0]   unit_rst_q;
  logic                   ready_q;
  logic [SEQ_COUNT_W-1:0] seq_count_q;
  logic                   req_pulse_s;

  rst_seq_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i       (CLK),
    .rst_i       (RST),
    .soft_req_i  (SOFT_REQ),
    .req_pulse_o (req_pulse_s)
  );

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      unit_idx_q  <= '0;
      sys_rst_q   <= 1'b1;
      unit_rst_q  <= '1;
      ready_q     <= 1'b0;
      seq_count_q <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= ST_STAGGER;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            unit_idx_q <= '0;
            sys_rst_q  <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_STAGGER: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= '0;
            // Ascending release: shift a zero in from the LSB end.
            unit_rst_q <= unit_rst_q << 1'b1;
            if (unit_idx_q == IDX_LAST) begin
              state_q    <= ST_RUN;
              unit_idx_q <= '0;
              ready_q    <= 1'b1;
              if (seq_count_q != SEQ_COUNT_MAX) begin
                seq_count_q <= seq_count_q + 8'd1;
              end else begin
                seq_count_q <= seq_count_q;
              end
            end else begin
              unit_idx_q <= unit_idx_q + 1'b1;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          // Soft requests are only honoured once the sequence has completed.
          if (req_pulse_s) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            sys_rst_q  <= 1'b1;
            unit_rst_q <= '1;
            ready_q    <= 1'b0;
          end else begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q    <= ST_HOLD;
          hold_cnt_q <= '0;
          gap_cnt_q  <= '0;
          unit_idx_q <= '0;
          sys_rst_q  <= 1'b1;
          unit_rst_q <= '1;
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  assign SYS_RST   = sys_rst_q;
  assign UNIT_RST  = unit_rst_q;
  assign READY     = ready_q;
  assign SEQ_COUNT = seq_count_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: two instances (4 units and 1 unit) share the
// stimulus; a timeline reference model predicts every output each edge.
module tb_rst_seq;

  localparam int H_A = 4;
  localparam int S_A = 16;
  localparam int N_A = 4;
  localparam int H_B = 3;
  localparam int S_B = 5;
  localparam int N_B = 1;
  localparam int DEB = 8;
`ifdef RST_SEQ_DEBOUNCE_EN
  localparam int DEB_MODEL = 8;
`else
  localparam int DEB_MODEL = 1;
`endif
  localparam int MAXE = 50000;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SOFT_REQ;
  logic       sys_a, ready_a, sys_b, ready_b;
  logic [3:0] unit_a;
  logic [0:0] unit_b;
  logic [7:0] cnt_a, cnt_b;

  always #5 CLK = ~CLK;

  rst_seq #(.NUM_UNITS(N_A), .HOLD_CYCLES(H_A), .STAGGER_CYCLES(S_A), .DEBOUNCE_CYCLES(DEB)) dut_a (
    .CLK(CLK), .RST(RST), .SOFT_REQ(SOFT_REQ),
    .SYS_RST(sys_a), .UNIT_RST(unit_a), .READY(ready_a), .SEQ_COUNT(cnt_a));

  rst_seq #(.NUM_UNITS(N_B), .HOLD_CYCLES(H_B), .STAGGER_CYCLES(S_B), .DEBOUNCE_CYCLES(DEB)) dut_b (
    .CLK(CLK), .RST(RST), .SOFT_REQ(SOFT_REQ),
    .SYS_RST(sys_b), .UNIT_RST(unit_b), .READY(ready_b), .SEQ_COUNT(cnt_b));

  typedef struct packed {
    int         edge_no;
    logic [13:0] a;   // {sys, unit[3:0], ready, cnt[7:0]}
    logic [10:0] b;   // {sys, unit[0], ready, cnt[7:0]}
  } exp_t;

  exp_t exp_q[$];
  bit   rst_h[MAXE];
  bit   soft_h[MAXE];
  int   n_edge = 0;
  int   start_m[2];
  int   cnt_m[2];
  int   vectors = 0;
  int   miscompares = 0;

  // Synchronised request level after edge m: SOFT_REQ two flops late, zeroed by RST.
  function automatic bit syn(input int m);
    if (m < 1) return 1'b0;
    if (rst_h[m] || rst_h[m-1]) return 1'b0;
    return soft_h[m-1];
  endfunction

  function automatic bit qual(input int m);
    for (int d = 1; d <= DEB_MODEL; d++) begin
      if (!syn(m - d)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // A request pulse is presented to the sequencer after edge m.
  function automatic bit req_at(input int m);
    if (m < 1) return 1'b0;
    return !rst_h[m] && qual(m) && !qual(m - 1);
  endfunction

  // Drive one cycle of inputs, predict outputs after the coming edge, push.
  task automatic apply(input bit r, input bit s);
    exp_t e;
    int   h, sg, nu, tot, t;
    if (n_edge + 1 >= MAXE) begin
      $display("FAIL edge_budget got %0d edges limit %0d", n_edge + 1, MAXE);
      $fatal(1);
    end
    RST      = r;
    SOFT_REQ = s;
    n_edge++;
    rst_h[n_edge]  = r;
    soft_h[n_edge] = s;
    e = '0;
    e.edge_no = n_edge;
    for (int j = 0; j < 2; j++) begin
      h   = (j == 0) ? H_A : H_B;
      sg  = (j == 0) ? S_A : S_B;
      nu  = (j == 0) ? N_A : N_B;
      tot = h + nu * sg;
      if (r) begin
        start_m[j] = n_edge;
        cnt_m[j]   = 0;
      end else begin
        if (req_at(n_edge - 1) && (n_edge - 1 - start_m[j]) >= tot) start_m[j] = n_edge;
        if (n_edge - start_m[j] == tot) cnt_m[j] = (cnt_m[j] < 255) ? cnt_m[j] + 1 : 255;
      end
      t = n_edge - start_m[j];
      if (j == 0) begin
        e.a[13] = (t < h);
        for (int i = 0; i < N_A; i++) e.a[9 + i] = (t < h + (i + 1) * sg);
        e.a[8]   = (t >= tot);
        e.a[7:0] = 8'(cnt_m[0]);
      end else begin
        e.b[10]  = (t < h);
        e.b[9]   = (t < h + sg);
        e.b[8]   = (t >= tot);
        e.b[7:0] = 8'(cnt_m[1]);
      end
    end
    exp_q.push_back(e);
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) apply(1'b0, 1'b0);
  endtask

  task automatic soft_pulse(input int w);
    for (int i = 0; i < w; i++) apply(1'b0, 1'b1);
  endtask

  // Monitor: pop one expectation per edge and compare both instances.
  initial begin
    exp_t       e;
    logic [13:0] got_a;
    logic [10:0] got_b;
    forever begin
      @(negedge CLK);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard_underflow got 0 queued expectations required at least 1");
      end else begin
        e     = exp_q.pop_front();
        got_a = {sys_a, unit_a, ready_a, cnt_a};
        got_b = {sys_b, unit_b, ready_b, cnt_b};
        vectors++;
        if (got_a !== e.a) begin
          miscompares++;
          $display("FAIL inst_a edge %0d got sys=%b unit=%b ready=%b cnt=%0d required sys=%b unit=%b ready=%b cnt=%0d",
                   e.edge_no, got_a[13], got_a[12:9], got_a[8], got_a[7:0],
                   e.a[13], e.a[12:9], e.a[8], e.a[7:0]);
        end
        vectors++;
        if (got_b !== e.b) begin
          miscompares++;
          $display("FAIL inst_b edge %0d got sys=%b unit=%b ready=%b cnt=%0d required sys=%b unit=%b ready=%b cnt=%0d",
                   e.edge_no, got_b[10], got_b[9], got_b[8], got_b[7:0],
                   e.b[10], e.b[9], e.b[8], e.b[7:0]);
        end
      end
    end
  end

  // Stimulus: directed scenarios, random mix, then drive SEQ_COUNT to saturation.
  initial begin
    int iter;
    int extra;
    RST        = 1'b1;
    SOFT_REQ   = 1'b0;
    start_m[0] = 0;
    start_m[1] = 0;
    cnt_m[0]   = 0;
    cnt_m[1]   = 0;

    repeat (3) apply(1'b1, 1'b0);
    idle(80);

    repeat (3) apply(1'b1, 1'b0);
    idle(39);
    apply(1'b1, 1'b0);
    idle(80);

    soft_pulse(1);
    idle(90);
    soft_pulse(200);
    idle(90);

    soft_pulse(1);
    idle(30);
    soft_pulse(1);
    idle(90);

    soft_pulse(7);
    idle(90);
    soft_pulse(8);
    idle(90);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 3)) apply(1'b1, 1'b0);
      end else begin
        soft_pulse($urandom_range(1, 10));
      end
      idle($urandom_range(20, 100));
    end

    iter  = 0;
    extra = 0;
    while ((cnt_m[0] < 255 || cnt_m[1] < 255 || extra < 5) && iter < 400) begin
      if (cnt_m[0] == 255 && cnt_m[1] == 255) extra++;
      soft_pulse($urandom_range(1, 3));
      idle($urandom_range(66, 100));
      iter++;
    end

    apply(1'b1, 1'b0);
    idle(10);

    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised reset sequencer for multi-unit designs. It sits between the board-level power-on reset and the `scalable_proc` fabric. After reset it holds every domain in reset for a fixed time, then releases the shared system logic (UART, interconnect). After that it releases the `NUM_PROCESSING_UNITS` units one at a time, spaced by a programmable interval, so their start-up activity does not overlap. A soft-reset request input re-runs the whole sequence without a board reset.

## Interface
- `NUM_UNITS`, default 4: number of unit reset outputs; legal range 1..32.
- `HOLD_CYCLES`, default 4: cycles all outputs stay asserted after `RST` falls; must be ≥1.
- `STAGGER_CYCLES`, default 16: gap between successive releases; must be ≥1.
- `DEBOUNCE_CYCLES`, default 1024: consecutive high samples needed on `SOFT_REQ`; used only when debounce is compiled in; must be ≥1.
- `CLK`, in, 1: the single clock; all logic is on its rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `SOFT_REQ`, in, 1: asynchronous soft-reset request (switch or UART break).
- `SYS_RST`, out, 1: active-high reset for the shared system logic.
- `UNIT_RST`, out, `NUM_UNITS`: active-high per-unit resets.
- `READY`, out, 1: high once every reset is released.
- `SEQ_COUNT`, out, 8: number of completed sequences; saturates at 255.

## Operation
- State machine states:
  - HOLD: `SYS_RST`=1, all `UNIT_RST`=1, counting `HOLD_CYCLES`.
  - STAGGER: `SYS_RST`=0, releasing units; index `i` runs 0..`NUM_UNITS`-1 and a gap counter counts `STAGGER_CYCLES`.
  - RUN: all outputs released, `READY`=1.
- Transitions:
  - HOLD → STAGGER when the hold count is exhausted.
  - STAGGER releases `UNIT_RST[i]` each time the gap counter is exhausted, then increments `i`.
  - STAGGER → RUN on the same edge that releases the last unit.
  - RUN → HOLD on an accepted soft request.
- Units release in ascending order. A released unit stays released until the next HOLD.
- `SOFT_REQ` passes through a 2-flop synchroniser. A request is accepted on the rising edge of the qualified signal.
  - The signal must return low before another request is accepted; holding `SOFT_REQ` high does not cause repeated sequences.
  - Requests arriving in HOLD or STAGGER are dropped, not queued.
- `SEQ_COUNT` increments on the edge `READY` rises and saturates at 255. Only `RST` clears it; a soft reset does not.
- Counter widths are $clog2(max count + 1); there is no wrap-around in any counter.

## Timing
- While `RST`=1, at each edge: `SYS_RST`=1, `UNIT_RST`=all ones, `READY`=0, `SEQ_COUNT`=0, state=HOLD, and the synchroniser and debounce are cleared.
- Latency: number the edges from the first edge with `RST`=0 as edge 1.
  - `SYS_RST` falls after edge `HOLD_CYCLES`.
  - `UNIT_RST[i]` falls after edge `HOLD_CYCLES` + (i+1)·`STAGGER_CYCLES`.
  - `READY` rises together with the last unit release.
- If `RST` is asserted mid-sequence, or in RUN, all outputs return to their reset values at the next edge and the sequence restarts from edge 1 once `RST` falls.
- Soft request without debounce: if `SOFT_REQ` is sampled high at edge k in RUN, all resets and `READY`=0 are visible after edge k+3. The release timeline then repeats, counted from edge k+3.
- `RST` and a soft request arriving together: `RST` wins.

## Configuration
- Macro: `RST_SEQ_DEBOUNCE_EN`.
- Defined: the synchronised `SOFT_REQ` must be high for `DEBOUNCE_CYCLES` consecutive cycles before the request qualifies. Any low sample resets the debounce count. Acceptance latency becomes k+3+`DEBOUNCE_CYCLES`−1.
- Undefined: no debounce logic is built and the synchronised signal is used directly. The `DEBOUNCE_CYCLES` parameter is retained but ignored.

## Structure
- Package `rst_seq_pkg` holds:
  - the state enum (HOLD, STAGGER, RUN);
  - the `SEQ_COUNT` width constant (8);
  - a counter-width helper function.
- Sub-module `rst_seq_debounce` contains the 2-flop synchroniser, the optional debounce counter and the rising-edge detector. Its output is a one-cycle `req_pulse`.

## Test plan
- Power-on, `NUM_UNITS`=4, `HOLD_CYCLES`=4, `STAGGER_CYCLES`=16; `RST` high for 3 cycles, then low:
  - `SYS_RST` falls after edge 4;
  - `UNIT_RST` steps 1111 → 1110 (edge 20) → 1100 (36) → 1000 (52) → 0000 (68);
  - `READY`=1 and `SEQ_COUNT`=1 at edge 68.
- `RST` pulsed at edge 40 (units 0–1 released): all outputs return to reset after that edge, then the timeline repeats from the fall of `RST`.
- In RUN, debounce off: `SOFT_REQ` high for 1 cycle → resets reasserted 3 edges later; `SEQ_COUNT`=2 after the rerun; `SOFT_REQ` held high 200 cycles produces only one sequence.
- `SOFT_REQ` pulsed during STAGGER → ignored; the timeline is unchanged and `SEQ_COUNT` increments exactly once.
- `RST_SEQ_DEBOUNCE_EN` defined, `DEBOUNCE_CYCLES`=8:
  - 7-cycle `SOFT_REQ` pulse → no reset;
  - 8-cycle pulse → resets asserted at k+10.
- 256 soft-reset sequences → `SEQ_COUNT` holds at 255; `NUM_UNITS`=1 → `READY` rises after edge `HOLD_CYCLES`+`STAGGER_CYCLES`.
